// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives one 2-bit control field per pipeline register,
// arbitrating trap, memory block, branch redirect, load-use and I-cache miss.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int BR_STAGE   = 2,
   parameter int ADDR_W     = 32,
   parameter int SHADOW     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    icache_data_valid_i,
   input  logic                    dcache_ready_i,
   input  logic                    mem_block_flag_i,
   input  logic                    load_use_i,
   input  logic                    ex_branch_flag_i,
   input  logic [ADDR_W-1:0]       ex_pc_new_i,
   input  logic                    trap_flag_i,
   input  logic [ADDR_W-1:0]       trap_pc_i,
   output logic [2*NUM_STAGES-1:0] ctrl_signal_o,
   output logic [ADDR_W-1:0]       ctrl_to_pc_new_o,
   output logic [CNT_W-1:0]        stall_cnt_o,
   output logic [1:0]              state_dbg_o
);
   localparam int CW = 2 * NUM_STAGES;
   localparam logic [1:0] C_NORMAL = 2'b00;
   localparam logic [1:0] C_STALL  = 2'b01;
   localparam logic [1:0] C_FLUSH  = 2'b10;
   localparam logic [1:0] C_REDIR  = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_REDIR    = 2'd2,
      ST_SHADOW   = 2'd3
   } state_t;

   function automatic logic [CW-1:0] mk_fill(input logic [1:0] code);
      logic [CW-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_STAGES; k++) v[2*k +: 2] = code;
      return v;
   endfunction

   function automatic logic [CW-1:0] mk_redirect();
      logic [CW-1:0] v;
      v = mk_fill(C_NORMAL);
      v[1:0] = C_REDIR;
      for (int k = 1; k <= BR_STAGE; k++) v[2*k +: 2] = C_FLUSH;
      return v;
   endfunction

   function automatic logic [CW-1:0] mk_load_use();
      logic [CW-1:0] v;
      v = mk_fill(C_NORMAL);
      for (int k = 0; k < BR_STAGE; k++) v[2*k +: 2] = C_STALL;
      v[2*BR_STAGE +: 2] = C_FLUSH;
      return v;
   endfunction

   function automatic logic [CW-1:0] mk_imiss();
      logic [CW-1:0] v;
      v = mk_fill(C_NORMAL);
      v[1:0] = C_STALL;
      v[3:2] = C_FLUSH;
      return v;
   endfunction

   function automatic logic [CW-1:0] mk_trap();
      logic [CW-1:0] v;
      v = mk_fill(C_FLUSH);
      v[1:0] = C_REDIR;
      return v;
   endfunction

   localparam logic [CW-1:0] PAT_STALL    = mk_fill(C_STALL);
   localparam logic [CW-1:0] PAT_REDIR    = mk_redirect();
   localparam logic [CW-1:0] PAT_LOAD_USE = mk_load_use();
   localparam logic [CW-1:0] PAT_IMISS    = mk_imiss();
   localparam logic [CW-1:0] PAT_TRAP     = mk_trap();
   // With a zero-length shadow a redirect returns straight to RUN.
   localparam state_t        POST_REDIR   = (SHADOW == 0) ? ST_RUN : ST_SHADOW;
   localparam logic [2:0]    SHADOW_LEN   = 3'(SHADOW);

   state_t              state_q, state_d;
   logic                pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
   logic [2:0]          shadow_q, shadow_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [CW-1:0]       ctrl;
   logic [ADDR_W-1:0]   pc_new;

   always_comb begin
      state_d    = state_q;
      pend_vld_d = pend_vld_q;
      pend_pc_d  = pend_pc_q;
      shadow_d   = shadow_q;
      ctrl       = '0;
      pc_new     = '0;
      if (trap_flag_i) begin
         ctrl       = PAT_TRAP;
         pc_new     = trap_pc_i;
         pend_vld_d = 1'b0;
         state_d    = POST_REDIR;
         shadow_d   = SHADOW_LEN;
      end else begin
         unique case (state_q)
            ST_RUN, ST_SHADOW: begin
               if (mem_block_flag_i) begin
                  ctrl     = PAT_STALL;
                  state_d  = ST_MEM_WAIT;
                  shadow_d = '0;
                  if (state_q == ST_RUN && ex_branch_flag_i) begin
                     pend_pc_d  = ex_pc_new_i;
                     pend_vld_d = 1'b1;
                  end
               end else begin
                  if (state_q == ST_RUN && ex_branch_flag_i) begin
                     ctrl     = PAT_REDIR;
                     pc_new   = ex_pc_new_i;
                     state_d  = POST_REDIR;
                     shadow_d = SHADOW_LEN;
                  end else if (load_use_i) begin
                     ctrl = PAT_LOAD_USE;
                  end else if (!icache_data_valid_i) begin
                     ctrl = PAT_IMISS;
                  end
                  if (state_q == ST_SHADOW) begin
                     if (shadow_q <= 3'd1) begin
                        shadow_d = '0;
                        state_d  = ST_RUN;
                     end else begin
                        shadow_d = shadow_q - 3'd1;
                     end
                  end
               end
            end
            ST_MEM_WAIT: begin
               ctrl = PAT_STALL;
               if (ex_branch_flag_i) begin
                  pend_pc_d  = ex_pc_new_i;
                  pend_vld_d = 1'b1;
               end
               if (dcache_ready_i) state_d = pend_vld_d ? ST_REDIR : ST_RUN;
            end
            ST_REDIR: begin
               // A new block postpones the held redirect; pend_vld stays set.
               if (mem_block_flag_i) begin
                  ctrl    = PAT_STALL;
                  state_d = ST_MEM_WAIT;
               end else begin
                  ctrl       = PAT_REDIR;
                  pc_new     = pend_pc_q;
                  pend_vld_d = 1'b0;
                  state_d    = POST_REDIR;
                  shadow_d   = SHADOW_LEN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
      if (ctrl[1:0] == C_STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      else                                            stall_cnt_d = stall_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         pend_vld_q  <= 1'b0;
         pend_pc_q   <= '0;
         shadow_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= pend_vld_d;
         pend_pc_q   <= pend_pc_d;
         shadow_q    <= shadow_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ctrl_signal_o    = rst ? ctrl : '0;
   assign ctrl_to_pc_new_o = rst ? pc_new : '0;
   assign stall_cnt_o      = stall_cnt_q;
   assign state_dbg_o      = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: each task plays a step table through a driver
// that queues expected outputs, then pops and compares them on the falling edge.
module tb_pipe_hazard_ctrl;
   localparam logic [5:0] IC = 6'b100000;
   localparam logic [5:0] DR = 6'b010000;
   localparam logic [5:0] MB = 6'b001000;
   localparam logic [5:0] LU = 6'b000100;
   localparam logic [5:0] BR = 6'b000010;
   localparam logic [5:0] TR = 6'b000001;

   localparam logic [9:0] E_NORM  = 10'h000;
   localparam logic [9:0] E_STALL = 10'h155;
   localparam logic [9:0] E_REDIR = 10'h02B;
   localparam logic [9:0] E_LU    = 10'h025;
   localparam logic [9:0] E_IMISS = 10'h009;
   localparam logic [9:0] E_TRAP  = 10'h2AB;

   typedef struct {
      logic [5:0]  flags;
      logic [31:0] bpc;
      logic [31:0] tpc;
      logic [9:0]  ectl;
      logic [31:0] epc;
   } step_t;

   logic        clk;
   logic        rst;
   logic        icache_data_valid_i, dcache_ready_i, mem_block_flag_i, load_use_i;
   logic        ex_branch_flag_i, trap_flag_i;
   logic [31:0] ex_pc_new_i, trap_pc_i;
   logic [9:0]  ctrl_signal_o, ctrl_c3;
   logic [31:0] ctrl_to_pc_new_o, pc_c3;
   logic [15:0] stall_cnt_o;
   logic [2:0]  stall_cnt_c3;
   logic [1:0]  state_dbg_o, state_c3;

   logic [60:0] exp_q[$];
   logic [15:0] exp_cnt;
   logic [2:0]  exp_cnt3;
   int          checks;
   int          errors;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .icache_data_valid_i(icache_data_valid_i), .dcache_ready_i(dcache_ready_i),
      .mem_block_flag_i(mem_block_flag_i), .load_use_i(load_use_i),
      .ex_branch_flag_i(ex_branch_flag_i), .ex_pc_new_i(ex_pc_new_i),
      .trap_flag_i(trap_flag_i), .trap_pc_i(trap_pc_i),
      .ctrl_signal_o(ctrl_signal_o), .ctrl_to_pc_new_o(ctrl_to_pc_new_o),
      .stall_cnt_o(stall_cnt_o), .state_dbg_o(state_dbg_o)
   );

   pipe_hazard_ctrl #(.CNT_W(3)) dut_c3 (
      .clk(clk), .rst(rst),
      .icache_data_valid_i(icache_data_valid_i), .dcache_ready_i(dcache_ready_i),
      .mem_block_flag_i(mem_block_flag_i), .load_use_i(load_use_i),
      .ex_branch_flag_i(ex_branch_flag_i), .ex_pc_new_i(ex_pc_new_i),
      .trap_flag_i(trap_flag_i), .trap_pc_i(trap_pc_i),
      .ctrl_signal_o(ctrl_c3), .ctrl_to_pc_new_o(pc_c3),
      .stall_cnt_o(stall_cnt_c3), .state_dbg_o(state_c3)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver ----------------
   function automatic step_t st(input logic [5:0] f, input logic [31:0] bpc,
                                input logic [31:0] tpc, input logic [9:0] ectl,
                                input logic [31:0] epc);
      step_t s;
      s.flags = f; s.bpc = bpc; s.tpc = tpc; s.ectl = ectl; s.epc = epc;
      return s;
   endfunction

   task automatic drive_step(input step_t s);
      icache_data_valid_i = s.flags[5];
      dcache_ready_i      = s.flags[4];
      mem_block_flag_i    = s.flags[3];
      load_use_i          = s.flags[2];
      ex_branch_flag_i    = s.flags[1];
      trap_flag_i         = s.flags[0];
      ex_pc_new_i         = s.bpc;
      trap_pc_i           = s.tpc;
      exp_q.push_back({s.ectl, s.epc, exp_cnt, exp_cnt3});
      if (s.ectl[1:0] == 2'b01) begin
         if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         if (exp_cnt3 != 3'd7) exp_cnt3 = exp_cnt3 + 3'd1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      step_t s[$];
      logic [60:0] e;
      rst = 1'b0;
      drive_step(st(IC | MB | BR | TR, 32'h11, 32'h22, E_NORM, 32'h0));
      void'(exp_q.pop_front());
      #12;
      checks++; if (ctrl_signal_o !== 10'h000) begin errors++; $display("FAIL reset_ctrl got %h exp 000", ctrl_signal_o); end
      checks++; if (ctrl_to_pc_new_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", ctrl_to_pc_new_o); end
      checks++; if (stall_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt_o); end
      checks++; if (state_dbg_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg_o); end
      @(posedge clk); #1;
      exp_cnt = '0; exp_cnt3 = '0;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) s.push_back(st(IC, 32'h0, 32'h0, E_NORM, 32'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_signal_o !== e[60:51]) begin errors++; $display("FAIL idle_ctrl step %0d got %h exp %h", i, ctrl_signal_o, e[60:51]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL idle_cnt step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_block();
      step_t s[$];
      logic [60:0] e;
      s.push_back(st(IC | MB, 32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC,      32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | BR, 32'h100, 32'h0, E_STALL, 32'h0));
      s.push_back(st(IC,      32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | DR, 32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC,      32'h0,   32'h0, E_REDIR, 32'h100));
      s.push_back(st(IC | BR, 32'h999, 32'h0, E_NORM,  32'h0));
      s.push_back(st(IC,      32'h0,   32'h0, E_NORM,  32'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_signal_o !== e[60:51]) begin errors++; $display("FAIL memblk_ctrl step %0d got %h exp %h", i, ctrl_signal_o, e[60:51]); end
         checks++; if (ctrl_to_pc_new_o !== e[50:19]) begin errors++; $display("FAIL memblk_pc step %0d got %h exp %h", i, ctrl_to_pc_new_o, e[50:19]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL memblk_cnt step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      step_t s[$];
      logic [60:0] e;
      s.push_back(st(IC | BR, 32'h8000_0040, 32'h0, E_REDIR, 32'h8000_0040));
      s.push_back(st(IC | BR, 32'h1234,      32'h0, E_NORM,  32'h0));
      s.push_back(st(IC | BR, 32'h2000,      32'h0, E_REDIR, 32'h2000));
      s.push_back(st(IC,      32'h0,         32'h0, E_NORM,  32'h0));
      s.push_back(st(BR,      32'h3000,      32'h0, E_REDIR, 32'h3000));
      s.push_back(st(6'b0,    32'h0,         32'h0, E_IMISS, 32'h0));
      s.push_back(st(IC,      32'h0,         32'h0, E_NORM,  32'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_signal_o !== e[60:51]) begin errors++; $display("FAIL branch_ctrl step %0d got %h exp %h", i, ctrl_signal_o, e[60:51]); end
         checks++; if (ctrl_to_pc_new_o !== e[50:19]) begin errors++; $display("FAIL branch_pc step %0d got %h exp %h", i, ctrl_to_pc_new_o, e[50:19]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL branch_cnt step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      step_t s[$];
      logic [60:0] e;
      s.push_back(st(IC | LU,      32'h0,  32'h0, E_LU,    32'h0));
      s.push_back(st(LU,           32'h0,  32'h0, E_LU,    32'h0));
      s.push_back(st(6'b0,         32'h0,  32'h0, E_IMISS, 32'h0));
      s.push_back(st(IC | LU | BR, 32'h40, 32'h0, E_REDIR, 32'h40));
      s.push_back(st(IC | LU,      32'h0,  32'h0, E_LU,    32'h0));
      s.push_back(st(IC,           32'h0,  32'h0, E_NORM,  32'h0));
      s.push_back(st(IC | MB | LU, 32'h0,  32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | DR,      32'h0,  32'h0, E_STALL, 32'h0));
      s.push_back(st(IC,           32'h0,  32'h0, E_NORM,  32'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_signal_o !== e[60:51]) begin errors++; $display("FAIL loaduse_ctrl step %0d got %h exp %h", i, ctrl_signal_o, e[60:51]); end
         checks++; if (ctrl_to_pc_new_o !== e[50:19]) begin errors++; $display("FAIL loaduse_pc step %0d got %h exp %h", i, ctrl_to_pc_new_o, e[50:19]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL loaduse_cnt step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_trap();
      step_t s[$];
      logic [60:0] e;
      s.push_back(st(IC | MB | BR,           32'h200, 32'h0,  E_STALL, 32'h0));
      s.push_back(st(IC | TR,                32'h0,   32'h4,  E_TRAP,  32'h4));
      s.push_back(st(IC | DR,                32'h0,   32'h0,  E_NORM,  32'h0));
      s.push_back(st(IC,                     32'h0,   32'h0,  E_NORM,  32'h0));
      s.push_back(st(IC | MB | LU | BR | TR, 32'h777, 32'h80, E_TRAP,  32'h80));
      s.push_back(st(IC | TR,                32'h0,   32'hC0, E_TRAP,  32'hC0));
      s.push_back(st(IC | BR,                32'h11,  32'h0,  E_NORM,  32'h0));
      s.push_back(st(IC | BR,                32'h22,  32'h0,  E_REDIR, 32'h22));
      s.push_back(st(IC,                     32'h0,   32'h0,  E_NORM,  32'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_signal_o !== e[60:51]) begin errors++; $display("FAIL trap_ctrl step %0d got %h exp %h", i, ctrl_signal_o, e[60:51]); end
         checks++; if (ctrl_to_pc_new_o !== e[50:19]) begin errors++; $display("FAIL trap_pc step %0d got %h exp %h", i, ctrl_to_pc_new_o, e[50:19]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL trap_cnt step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      logic [60:0] e;
      s.push_back(st(IC | MB | BR, 32'h300, 32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | DR,      32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | MB,      32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | DR,      32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC,           32'h0,   32'h0, E_REDIR, 32'h300));
      s.push_back(st(IC,           32'h0,   32'h0, E_NORM,  32'h0));
      s.push_back(st(IC | BR,      32'h400, 32'h0, E_REDIR, 32'h400));
      s.push_back(st(IC | MB | BR, 32'h500, 32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | DR,      32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC,           32'h0,   32'h0, E_NORM,  32'h0));
      s.push_back(st(IC | MB | BR, 32'h600, 32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | BR,      32'h700, 32'h0, E_STALL, 32'h0));
      s.push_back(st(IC | DR,      32'h0,   32'h0, E_STALL, 32'h0));
      s.push_back(st(IC,           32'h0,   32'h0, E_REDIR, 32'h700));
      s.push_back(st(IC,           32'h0,   32'h0, E_NORM,  32'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_signal_o !== e[60:51]) begin errors++; $display("FAIL b2b_ctrl step %0d got %h exp %h", i, ctrl_signal_o, e[60:51]); end
         checks++; if (ctrl_to_pc_new_o !== e[50:19]) begin errors++; $display("FAIL b2b_pc step %0d got %h exp %h", i, ctrl_to_pc_new_o, e[50:19]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL b2b_cnt step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturation();
      step_t s[$];
      logic [60:0] e;
      drive_step(st(IC, 32'h0, 32'h0, E_NORM, 32'h0));
      void'(exp_q.pop_front());
      rst = 1'b0;
      #2;
      rst = 1'b1;
      exp_cnt = '0; exp_cnt3 = '0;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) s.push_back(st(IC | MB, 32'h0, 32'h0, E_STALL, 32'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_c3 !== e[60:51]) begin errors++; $display("FAIL sat_ctrl step %0d got %h exp %h", i, ctrl_c3, e[60:51]); end
         checks++; if (stall_cnt_c3 !== e[2:0]) begin errors++; $display("FAIL sat_cnt3 step %0d got %0d exp %0d", i, stall_cnt_c3, e[2:0]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL sat_cnt16 step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
      checks++; if (stall_cnt_c3 !== 3'd7) begin errors++; $display("FAIL sat_final got %0d exp 7", stall_cnt_c3); end
      checks++; if (stall_cnt_o !== 16'd10) begin errors++; $display("FAIL sat_final16 got %0d exp 10", stall_cnt_o); end
      #3;
      rst = 1'b0;
      #1;
      checks++; if (ctrl_signal_o !== 10'h000) begin errors++; $display("FAIL midrst_ctrl got %h exp 000", ctrl_signal_o); end
      checks++; if (stall_cnt_o !== 16'h0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", stall_cnt_o); end
      checks++; if (stall_cnt_c3 !== 3'h0) begin errors++; $display("FAIL midrst_cnt3 got %0d exp 0", stall_cnt_c3); end
      checks++; if (state_c3 !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d exp 0", state_c3); end
      @(posedge clk); #1;
      exp_cnt = '0; exp_cnt3 = '0;
      rst = 1'b1;
      s.delete();
      s.push_back(st(IC, 32'h0, 32'h0, E_NORM, 32'h0));
      s.push_back(st(IC | BR, 32'h55, 32'h0, E_REDIR, 32'h55));
      for (int i = 0; i < s.size(); i++) begin
         drive_step(s[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctrl_signal_o !== e[60:51]) begin errors++; $display("FAIL post_ctrl step %0d got %h exp %h", i, ctrl_signal_o, e[60:51]); end
         checks++; if (ctrl_to_pc_new_o !== e[50:19]) begin errors++; $display("FAIL post_pc step %0d got %h exp %h", i, ctrl_to_pc_new_o, e[50:19]); end
         checks++; if (stall_cnt_o !== e[18:3]) begin errors++; $display("FAIL post_cnt step %0d got %0d exp %0d", i, stall_cnt_o, e[18:3]); end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0; errors = 0;
      exp_cnt = '0; exp_cnt3 = '0;
      test_reset();
      test_mem_block();
      test_branch();
      test_load_use();
      test_trap();
      test_back_to_back();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the single-issue pipeline controller. Drives one 2-bit control field per pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, and any extra stages.
- Arbitrates trap, data-cache block, branch redirect, load-use hazard and I-cache miss by fixed priority.
- Holds a branch redirect that arrives during a memory block and applies it when the block releases.
- Sits beside the datapath. Counts stall cycles for performance monitoring.

Parameters:
- NUM_STAGES, 5, number of controlled registers; index 0 = PC, index k = register feeding stage k (min 4).
- BR_STAGE, 2, index of the register holding the instruction in EX (branch resolve point); 1 <= BR_STAGE < NUM_STAGES-1.
- ADDR_W, 32, PC width.
- SHADOW, 1, cycles after a redirect during which branch pulses are ignored (0..7).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- icache_data_valid_i  in  1  fetch data valid; 0 = I-cache miss.
- dcache_ready_i  in  1  D-cache finished the outstanding access.
- mem_block_flag_i  in  1  MEM stage requires block.
- load_use_i  in  1  ID detects load-use hazard.
- ex_branch_flag_i  in  1  single-cycle taken-branch/jump pulse from EX.
- ex_pc_new_i  in  ADDR_W  branch target, valid with ex_branch_flag_i.
- trap_flag_i  in  1  single-cycle trap pulse.
- trap_pc_i  in  ADDR_W  trap vector.
- ctrl_signal_o  out  2*NUM_STAGES  field k = bits [2k+1:2k].
- ctrl_to_pc_new_o  out  ADDR_W  redirect target, meaningful when field 0 = REDIRECT.
- stall_cnt_o  out  CNT_W  saturating count of cycles with field 0 = STALL.

Behaviour:
- Field codes: 00 NORMAL, 01 STALL (hold), 10 FLUSH (insert bubble), 11 REDIRECT (field 0 only; load ctrl_to_pc_new_o).
- Outputs are combinational from the registered state plus current inputs (Mealy). State, pend_vld, pend_pc, shadow counter and stall_cnt_o are registered.
- Reset (rst=0, asynchronous):
  - state RUN, pend_vld=0, pend_pc=0, shadow count=0, stall_cnt_o=0.
  - While rst=0, ctrl_signal_o = all 00 and ctrl_to_pc_new_o = 0.
  - Reset mid-block or mid-shadow discards everything.
- States: RUN, MEM_WAIT, REDIR, SHADOW.
- Priority in every state: trap > mem_block / MEM_WAIT > branch > load_use > I-cache miss.
- Trap (any state):
  - Field 0 = REDIRECT, target trap_pc_i; all other fields FLUSH.
  - pend_vld cleared. Next state SHADOW, or RUN if SHADOW=0.
- RUN / SHADOW:
  - mem_block_flag_i=1: all fields STALL. Next state MEM_WAIT. If ex_branch_flag_i=1 in the same cycle (accepted in RUN; ignored in SHADOW), capture pend_pc=ex_pc_new_i, pend_vld=1.
  - Accepted branch (RUN only; ignored in SHADOW): field 0 REDIRECT with target ex_pc_new_i; fields 1..BR_STAGE FLUSH; the rest NORMAL. Next state SHADOW, or RUN if SHADOW=0.
  - load_use_i: fields 0..BR_STAGE-1 STALL, field BR_STAGE FLUSH, the rest NORMAL.
  - icache_data_valid_i=0: field 0 STALL, field 1 FLUSH, the rest NORMAL.
  - Otherwise all NORMAL.
  - SHADOW decrements its counter each cycle and returns to RUN when the counter reaches 0. Entering MEM_WAIT abandons the shadow.
- MEM_WAIT:
  - All fields STALL every cycle, including the cycle dcache_ready_i=1.
  - A branch pulse overwrites pend_pc and sets pend_vld.
  - On dcache_ready_i=1: next state REDIR if pend_vld, else RUN.
- REDIR (one cycle):
  - Field 0 REDIRECT with target pend_pc; fields 1..BR_STAGE FLUSH; the rest NORMAL.
  - pend_vld cleared. Next state SHADOW, or RUN if SHADOW=0.
  - A mem_block in this cycle is honoured: outputs per the mem_block rule, next state MEM_WAIT, pend_vld kept.
- ctrl_to_pc_new_o = 0 whenever field 0 is not REDIRECT.
- stall_cnt_o increments every cycle with field 0 = STALL and saturates at 2^CNT_W-1.

Test Plan:
- Reset release, all inputs idle (icache_data_valid_i=1) → ctrl_signal_o=10'h000, stall_cnt_o=0 for 10 cycles.
- Branch pulse with target 0x8000_0040 in RUN → same cycle ctrl_signal_o=10'b00_00_10_10_11 and ctrl_to_pc_new_o=0x8000_0040; second pulse next cycle (SHADOW=1) ignored → all NORMAL.
- mem_block 1 cycle, dcache_ready_i after 3 cycles, branch pulse (0x100) in 2nd MEM_WAIT cycle → 5 cycles all-STALL (10'h155), then REDIR cycle with target 0x100, stall_cnt_o=5.
- load_use_i=1 alone → 10'b00_00_10_01_01; with icache_data_valid_i=0 also → load_use pattern wins.
- Trap (0x0000_0004) during MEM_WAIT with pending branch → 10'b10_10_10_10_11, target 0x4, pending discarded, no later REDIR.
- CNT_W=3: hold mem_block 10 cycles → stall_cnt_o saturates at 7; async rst mid-stall → counter and outputs 0 immediately.
